// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode barrel shifter (LSR/ASR/ROR/ROL) with valid/ready flow control.
// Define BARREL_SHIFT_PIPE_EN to register every log-stage; otherwise one output register.
module pipelined_barrel_shifter #(
   parameter int N  = 8,
   parameter int SW = $clog2(N)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [N-1:0]  i_num,
   input  logic [SW-1:0] i_amount,
   input  logic [1:0]    i_mode,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [N-1:0]  o_result,
   output logic          o_zero
);

   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_ASR = 2'b01;
   localparam logic [1:0] MODE_ROL = 2'b11;

   // One log-stage: shift by sh when en, filling from the mode-dependent upper half.
   function automatic logic [N-1:0] shift_stage(
      input logic [N-1:0] d,
      input logic [1:0]   mode,
      input logic         sign,
      input logic         en,
      input int unsigned  sh
   );
      logic [2*N-1:0] ext;
      case (mode)
         MODE_LSR: ext = {{N{1'b0}}, d};
         MODE_ASR: ext = {{N{sign}}, d};
         default:  ext = {d, d};
      endcase
      shift_stage = en ? N'(ext >> sh) : d;
   endfunction

   logic [SW-1:0] cap_amount_s;

   // Rotate left becomes rotate right by (N - amount) mod N at capture.
   always_comb begin
      if (i_mode == MODE_ROL) begin
         cap_amount_s = {SW{1'b0}} - i_amount;
      end else begin
         cap_amount_s = i_amount;
      end
   end

`ifdef BARREL_SHIFT_PIPE_EN

   logic [SW-1:0] valid_vec_s;
   logic [SW-1:0] ready_s;
   logic          full_s;

   // A stage may load when it or any stage after it has a free slot, or the sink drains.
   always_comb begin
      ready_s = {SW{1'b0}};
      full_s  = 1'b1;
      for (int k = 0; k < SW; k++) begin
         full_s = 1'b1;
         for (int j = k; j < SW; j++) begin
            full_s = full_s & valid_vec_s[j];
         end
         ready_s[k] = i_ready | ~full_s;
      end
   end

   for (genvar k = 0; k < SW; k++) begin : g_stage
      localparam int AW = SW - k;

      logic [N-1:0]  in_data_s;
      logic [AW-1:0] in_amt_s;
      logic [1:0]    in_mode_s;
      logic          in_sign_s;
      logic          in_valid_s;
      logic [N-1:0]  shifted_s;
      logic          valid_r;
      logic [N-1:0]  data_r;

      if (k == 0) begin : g_src
         assign in_data_s  = i_num;
         assign in_amt_s   = cap_amount_s;
         assign in_mode_s  = i_mode;
         assign in_sign_s  = i_num[N-1];
         assign in_valid_s = i_valid;
      end else begin : g_src
         assign in_data_s  = g_stage[k-1].data_r;
         assign in_amt_s   = g_stage[k-1].g_side.amt_r;
         assign in_mode_s  = g_stage[k-1].g_side.mode_r;
         assign in_sign_s  = g_stage[k-1].g_side.sign_r;
         assign in_valid_s = g_stage[k-1].valid_r;
      end

      // Remaining amount is consumed LSB-first, so each stage only looks at bit 0.
      assign shifted_s      = shift_stage(in_data_s, in_mode_s, in_sign_s, in_amt_s[0], 2**k);
      assign valid_vec_s[k] = valid_r;

      // Stage data and valid register.
      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {N{1'b0}};
         end else if (ready_s[k]) begin
            valid_r <= in_valid_s;
            if (in_valid_s) begin
               data_r <= shifted_s;
            end
         end
      end

      if (k < SW - 1) begin : g_side
         logic [AW-2:0] amt_r;
         logic [1:0]    mode_r;
         logic          sign_r;

         // Sideband travelling with the word.
         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               amt_r  <= {(AW-1){1'b0}};
               mode_r <= 2'b00;
               sign_r <= 1'b0;
            end else if (ready_s[k] && in_valid_s) begin
               amt_r  <= in_amt_s[AW-1:1];
               mode_r <= in_mode_s;
               sign_r <= in_sign_s;
            end
         end
      end else begin : g_last
         logic zero_r;

         // Zero flag registered alongside the final result.
         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               zero_r <= 1'b0;
            end else if (ready_s[k] && in_valid_s) begin
               zero_r <= (shifted_s == {N{1'b0}});
            end
         end
      end
   end

   assign o_ready  = ready_s[0];
   assign o_valid  = valid_vec_s[SW-1];
   assign o_result = g_stage[SW-1].data_r;
   assign o_zero   = g_stage[SW-1].g_last.zero_r;

`else

   logic [N-1:0] comb_data_s;
   logic         ready_s;
   logic         valid_r;
   logic [N-1:0] data_r;
   logic         zero_r;

   // Full shift network evaluated in one cycle.
   always_comb begin
      comb_data_s = i_num;
      for (int k = 0; k < SW; k++) begin
         comb_data_s = shift_stage(comb_data_s, i_mode, i_num[N-1], cap_amount_s[k], 1 << k);
      end
   end

   assign ready_s = ~valid_r | i_ready;

   // Single output register with the same handshake as a pipeline stage.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         valid_r <= 1'b0;
         data_r  <= {N{1'b0}};
         zero_r  <= 1'b0;
      end else if (ready_s) begin
         valid_r <= i_valid;
         if (i_valid) begin
            data_r <= comb_data_s;
            zero_r <= (comb_data_s == {N{1'b0}});
         end
      end
   end

   assign o_ready  = ready_s;
   assign o_valid  = valid_r;
   assign o_result = data_r;
   assign o_zero   = zero_r;

`endif

endmodule
